// File: rtl/disp_hex_mux_n_if.sv
// Digit-data and pin-side bundle for the multiplexed hex display driver.
// The master drives digit data and display controls; the slave drives the anode and segment pins.
interface disp_hex_mux_n_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DUTY_W     = 3
);
    logic [4*NUM_DIGITS-1:0] hex_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic [DUTY_W-1:0]       brightness;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              sseg;

    modport master (
        output hex_in, dp_in, blank_in, lz_en, brightness,
        input  an, sseg
    );

    modport slave (
        input  hex_in, dp_in, blank_in, lz_en, brightness,
        output an, sseg
    );
endinterface

// File: rtl/disp_hex_mux_n.sv
// Multiplexed common-anode hex driver with blanking, leading-zero suppression,
// PWM brightness, anti-ghost dead cycle and frame-coherent input snapshot.
module disp_hex_mux_n #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_W      = 16,
    parameter int DUTY_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    disp_hex_mux_n_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_lz;
    logic [DUTY_W-1:0]       r_bri;
    logic                    r_load_pend;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_sseg;

    logic                    w_cnt_wrap;
    logic                    w_snap;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [3:0]              w_hex_cur;
    logic [6:0]              w_glyph;
    logic                    w_lit;

    assign w_cnt_wrap = (r_cnt == '1);
    // Snapshot only at the frame boundary so a frame never mixes old and new digits.
    assign w_snap     = r_load_pend || (w_cnt_wrap && (r_idx == LAST_IDX));

    // Scan from the leftmost digit down; a digit is suppressed while every digit
    // to its left (and itself) is a zero without a decimal point.
    always_comb begin
        logic v_run;
        v_run  = 1'b1;
        w_supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_run = v_run && (r_hex[4*i +: 4] == 4'h0) && !r_dp[i];
            if (i != 0) w_supp[i] = r_lz && v_run;
        end
    end

    assign w_hex_cur = r_hex[4*r_idx +: 4];

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_hex_cur)
            4'h0: w_glyph = 7'b0000001;
            4'h1: w_glyph = 7'b1001111;
            4'h2: w_glyph = 7'b0010010;
            4'h3: w_glyph = 7'b0000110;
            4'h4: w_glyph = 7'b1001100;
            4'h5: w_glyph = 7'b0100100;
            4'h6: w_glyph = 7'b0100000;
            4'h7: w_glyph = 7'b0001111;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0000100;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b1100000;
            4'hC: w_glyph = 7'b0110001;
            4'hD: w_glyph = 7'b1000010;
            4'hE: w_glyph = 7'b0110000;
            4'hF: w_glyph = 7'b0111000;
            default: w_glyph = 7'b1111111;
        endcase
    end

    // cnt == 0 is the dead cycle that lets the old anode discharge before the next digit.
    assign w_lit = !r_blank[r_idx] && !w_supp[r_idx] && (r_cnt != '0)
                && (r_cnt[DIV_W-1 -: DUTY_W] <= r_bri);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_hex       <= '0;
            r_dp        <= '0;
            r_blank     <= '0;
            r_lz        <= 1'b0;
            r_bri       <= '0;
            r_load_pend <= 1'b1;
            r_an        <= '1;
            r_sseg      <= 8'hFF;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_wrap) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

            if (w_snap) begin
                r_hex       <= bus.hex_in;
                r_dp        <= bus.dp_in;
                r_blank     <= bus.blank_in;
                r_lz        <= bus.lz_en;
                r_bri       <= bus.brightness;
                r_load_pend <= 1'b0;
            end

            if (w_lit) begin
                r_an   <= ~(NUM_DIGITS'(1) << r_idx);
                r_sseg <= {~r_dp[r_idx], w_glyph};
            end else begin
                r_an   <= '1;
                r_sseg <= 8'hFF;
            end
        end
    end

    assign bus.an   = r_an;
    assign bus.sseg = r_sseg;
endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Directed bench for disp_hex_mux_n with 4 digits and 16-cycle slots; expected
// anode/segment values are hand-derived from the glyph table and slot timing.
module tb_disp_hex_mux_n;
    localparam int ND     = 4;
    localparam int DIV_W  = 4;
    localparam int DUTY_W = 2;

    localparam logic [7:0] S_0  = 8'b10000001;
    localparam logic [7:0] S_0D = 8'b00000001;
    localparam logic [7:0] S_1  = 8'b11001111;
    localparam logic [7:0] S_2  = 8'b10010010;
    localparam logic [7:0] S_2D = 8'b00010010;
    localparam logic [7:0] S_3  = 8'b10000110;
    localparam logic [7:0] S_4  = 8'b11001100;
    localparam logic [7:0] S_5  = 8'b10100100;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    disp_hex_mux_n_if #(.NUM_DIGITS(ND), .DUTY_W(DUTY_W)) bus ();

    disp_hex_mux_n #(.NUM_DIGITS(ND), .DIV_W(DIV_W), .DUTY_W(DUTY_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed {an,sseg}=%h expected %h", tag, obs, exp);
        end
    endtask

    // One 16-cycle slot: dead cycle, then nlit lit cycles, then dark for the remainder.
    task automatic check_slot(input string tag, input int digit, input logic [7:0] s_exp,
                              input int nlit);
        logic [3:0] an_on;
        an_on = ~(4'b0001 << digit);
        tick();
        check({tag, "_dead"}, {bus.an, bus.sseg}, {4'hF, 8'hFF});
        for (int c = 1; c < 16; c++) begin
            tick();
            if (c <= nlit) check(tag, {bus.an, bus.sseg}, {an_on, s_exp});
            else           check({tag, "_off"}, {bus.an, bus.sseg}, {4'hF, 8'hFF});
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset          = 1'b1;
        bus.hex_in     = 16'h1234;
        bus.dp_in      = 4'b0000;
        bus.blank_in   = 4'b0000;
        bus.lz_en      = 1'b0;
        bus.brightness = 2'd3;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset", {bus.an, bus.sseg}, {4'hF, 8'hFF});
        end
        reset = 1'b0;

        // Frame A: full brightness scan of 1234.
        check_slot("A_d0", 0, S_4, 15);
        check_slot("A_d1", 1, S_3, 15);
        check_slot("A_d2", 2, S_2, 15);
        bus.brightness = 2'd0;
        check_slot("A_d3", 3, S_1, 15);

        // Frame B: dimmest.
        check_slot("B_d0", 0, S_4, 3);
        check_slot("B_d1", 1, S_3, 3);
        check_slot("B_d2", 2, S_2, 3);
        bus.brightness = 2'd1;
        check_slot("B_d3", 3, S_1, 3);

        // Frame C: level 1; leading-zero setup queued for next frame.
        check_slot("C_d0", 0, S_4, 7);
        check_slot("C_d1", 1, S_3, 7);
        check_slot("C_d2", 2, S_2, 7);
        bus.brightness = 2'd3;
        bus.lz_en      = 1'b1;
        bus.hex_in     = 16'h0050;
        check_slot("C_d3", 3, S_1, 7);

        // Frame D: 0050 with suppression.
        check_slot("D_d0", 0, S_0, 15);
        check_slot("D_d1", 1, S_5, 15);
        check_slot("D_d2", 2, S_0, 0);
        bus.hex_in = 16'h0000;
        check_slot("D_d3", 3, S_0, 0);

        // Frame E: all zeros, only digit 0 survives.
        check_slot("E_d0", 0, S_0, 15);
        check_slot("E_d1", 1, S_0, 0);
        check_slot("E_d2", 2, S_0, 0);
        bus.hex_in = 16'h0050;
        bus.dp_in  = 4'b0100;
        check_slot("E_d3", 3, S_0, 0);

        // Frame F: decimal point on digit 2 stops suppression there.
        check_slot("F_d0", 0, S_0, 15);
        check_slot("F_d1", 1, S_5, 15);
        check_slot("F_d2", 2, S_0D, 15);
        bus.lz_en  = 1'b0;
        bus.dp_in  = 4'b0000;
        bus.hex_in = 16'h1111;
        check_slot("F_d3", 3, S_0, 0);

        // Frame G: input changes mid-frame must not tear the display.
        check_slot("G_d0", 0, S_1, 15);
        bus.hex_in = 16'h2222;
        check_slot("G_d1", 1, S_1, 15);
        check_slot("G_d2", 2, S_1, 15);
        bus.blank_in = 4'b0100;
        bus.dp_in    = 4'b0001;
        check_slot("G_d3", 3, S_1, 15);

        // Frame H: new value, digit 2 blanked, dp only on digit 0.
        check_slot("H_d0", 0, S_2D, 15);
        check_slot("H_d1", 1, S_2, 15);
        check_slot("H_d2", 2, S_2, 0);
        bus.blank_in = 4'b0000;
        check_slot("H_d3", 3, S_2, 15);

        // Reset in the middle of a lit slot.
        tick();
        check("I_dead", {bus.an, bus.sseg}, {4'hF, 8'hFF});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("I_d0", {bus.an, bus.sseg}, {4'b1110, S_2D});
        end
        reset = 1'b1;
        tick();
        check("midreset", {bus.an, bus.sseg}, {4'hF, 8'hFF});
        reset = 1'b0;
        bus.hex_in = 16'h0009;
        bus.dp_in  = 4'b0000;
        check_slot("R_d0", 0, 8'b10000100, 15);
        check_slot("R_d1", 1, S_0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
